// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 width codes,
// controller state type and the default BRAM word-address width.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 13;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LD_WAIT,
        ST_RMW_RD,
        ST_RMW_WR
    } dmem_state_t;

    // Misaligned half/word accesses and funct3 codes with no matching access width.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
        logic ill;
        ill = 1'b0;
        case (f3)
            F3_B, F3_BU: ill = 1'b0;
            F3_H, F3_HU: ill = lo[0];
            F3_W:        ill = (lo != 2'b00);
            default:     ill = 1'b1;
        endcase
        if (we && (f3 >= 3'd3))
            ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Lane formatting for the data-memory controller: load byte/half extraction
// with sign/zero extension, and sub-word lane replacement for store merges.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dout[7:0];
        case (addr_lo)
            2'd0: byte_sel = dout[7:0];
            2'd1: byte_sel = dout[15:8];
            2'd2: byte_sel = dout[23:16];
            2'd3: byte_sel = dout[31:24];
            default: byte_sel = dout[7:0];
        endcase
        half_sel = addr_lo[1] ? dout[31:16] : dout[15:0];
    end

    always_comb begin
        load_data = dout;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = dout;
        endcase
    end

    // Only sb/sh reach the merge path, so funct3[1:0] alone picks byte vs half.
    always_comb begin
        merge_data = dout;
        if (funct3[1:0] == 2'b00) begin
            case (addr_lo)
                2'd0: merge_data[7:0]   = wdata[7:0];
                2'd1: merge_data[15:8]  = wdata[7:0];
                2'd2: merge_data[23:16] = wdata[7:0];
                2'd3: merge_data[31:24] = wdata[7:0];
                default: merge_data = dout;
            endcase
        end else if (addr_lo[1]) begin
            merge_data[31:16] = wdata;
        end else begin
            merge_data[15:0] = wdata;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the MEM stage and a word-wide BRAM with a
// single write enable: word stores direct, sub-word stores via read-modify-write.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              access_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    dmem_state_t state, state_nxt;
    logic [31:0] merged_q;
    logic        merge_en;
    logic        illegal;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign mem_addr       = req_addr[ADDR_W+1:2];
    assign illegal        = req_illegal(req_we, req_funct3, req_addr[1:0]);

    dmem_lane_fmt u_lane_fmt (
        .dout       (mem_dout),
        .addr_lo    (req_addr[1:0]),
        .funct3     (req_funct3),
        .wdata      (req_wdata[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            merged_q <= '0;
        end else begin
            state <= state_nxt;
            if (merge_en)
                merged_q <= merge_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        rvalid     = 1'b0;
        access_err = 1'b0;
        mem_we     = 1'b0;
        merge_en   = 1'b0;
        mem_din    = req_wdata;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        access_err = 1'b1;
                    end else if (req_we) begin
                        if (req_funct3 == F3_W) begin
                            mem_we = 1'b1;
                        end else begin
                            stall     = 1'b1;
                            state_nxt = ST_RMW_RD;
                        end
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_LD_WAIT;
                    end
                end
            end
            ST_LD_WAIT: begin
                rvalid    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RMW_RD: begin
                stall     = 1'b1;
                merge_en  = 1'b1;
                state_nxt = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_we    = 1'b1;
                mem_din   = merged_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset overrides the handshake so an interrupted RMW never writes.
        if (!rst_n) begin
            stall      = 1'b0;
            rvalid     = 1'b0;
            access_err = 1'b0;
            mem_we     = 1'b0;
            merge_en   = 1'b0;
        end
    end

    assign rdata = rvalid ? load_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a BRAM model, a reference memory and
// write/read scoreboards checked at the falling clock edge.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned AW = 13;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          stall;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          access_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    int checks = 0;
    int fails  = 0;

    logic [31:0] bram [0:(1<<AW)-1];
    logic [31:0] refm [int];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] rq_data[$];
    logic        prev_stall = 1'b0;

    dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .access_err (access_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1)
            bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int k;
        k = int'(a[AW+1:2]);
        return refm.exists(k) ? refm[k] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [2:0] f3);
        logic [31:0] b, h;
        b = w >> (8 * lo);
        h = w >> (16 * lo[1]);
        case (f3)
            3'd0: return {{24{b[7]}}, b[7:0]};
            3'd4: return {24'd0, b[7:0]};
            3'd1: return {{16{h[15]}}, h[15:0]};
            3'd5: return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (f3 == 3'd2) return wd;
        sh   = (f3 == 3'd0) ? 8 * lo : 16 * lo[1];
        mask = ((f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wq_addr.size() == 0) begin
                chk("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                chk("wr_addr", 32'(mem_addr), wq_addr.pop_front());
                chk("wr_data", mem_din, wq_data.pop_front());
            end
        end
        if (rvalid === 1'b1) begin
            if (rq_data.size() == 0)
                chk("unexpected_rvalid", {31'd0, rvalid}, 32'd0);
            else
                chk("rdata", rdata, rq_data.pop_front());
        end else begin
            chk("rdata_idle", rdata, 32'd0);
        end
        if (rst_n === 1'b1 && prev_stall)
            chk("req_held_during_stall", {31'd0, req_valid}, 32'd1);
        prev_stall = (stall === 1'b1);
    end

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_stall, input logic exp_err);
        int stalls;
        logic [31:0] nw;
        if (!exp_err) begin
            if (we) begin
                nw = ref_merge(ref_rd(addr), addr[1:0], f3, wd);
                wq_addr.push_back(32'(addr[AW+1:2]));
                wq_data.push_back(nw);
                refm[int'(addr[AW+1:2])] = nw;
            end else begin
                rq_data.push_back(ref_load(ref_rd(addr), addr[1:0], f3));
            end
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        chk({tag, "_err"}, {31'd0, access_err}, {31'd0, exp_err});
        stalls = 0;
        while (stall === 1'b1 && stalls < 8) begin
            stalls++;
            @(negedge clk);
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'hCAFE_F00D;

        // A valid sw held during reset must produce nothing.
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, access_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_merged", dut.merged_q, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        do_req("sw_10", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        do_req("lw_10", 1'b0, F3_W, 32'h10, 32'h0, 1, 1'b0);

        do_req("sw_20", 1'b1, F3_W, 32'h20, 32'h1122_3344, 0, 1'b0);
        do_req("sb_21", 1'b1, F3_B, 32'h21, 32'h0000_00AA, 2, 1'b0);
        do_req("lb_21", 1'b0, F3_B, 32'h21, 32'h0, 1, 1'b0);
        do_req("lbu_21", 1'b0, F3_BU, 32'h21, 32'h0, 1, 1'b0);

        do_req("sh_22", 1'b1, F3_H, 32'h22, 32'h0000_8001, 2, 1'b0);
        do_req("lh_22", 1'b0, F3_H, 32'h22, 32'h0, 1, 1'b0);
        do_req("lhu_22", 1'b0, F3_HU, 32'h22, 32'h0, 1, 1'b0);
        do_req("lb_23", 1'b0, F3_B, 32'h23, 32'h0, 1, 1'b0);
        do_req("lhu_20", 1'b0, F3_HU, 32'h20, 32'h0, 1, 1'b0);

        do_req("lw_13", 1'b0, F3_W, 32'h13, 32'h0, 0, 1'b1);
        do_req("sh_21", 1'b1, F3_H, 32'h21, 32'h0000_1234, 0, 1'b1);
        do_req("ld_f3_3", 1'b0, 3'd3, 32'h20, 32'h0, 0, 1'b1);
        do_req("st_f3_4", 1'b1, 3'd4, 32'h20, 32'h0000_0077, 0, 1'b1);
        do_req("lw_20_a", 1'b0, F3_W, 32'h20, 32'h0, 1, 1'b0);

        // sb interrupted by reset while in RMW_RD: nothing may be written.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_B;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000_0055;
        @(negedge clk);
        chk("abort_stall_idle", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(dut.state), 32'(ST_IDLE));
        chk("abort_stall_after", {31'd0, stall}, 32'd0);
        chk("abort_mem_we_after", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        do_req("lw_20_b", 1'b0, F3_W, 32'h20, 32'h0, 1, 1'b0);

        do_req("sb_30", 1'b1, F3_B, 32'h30, 32'h0000_0001, 2, 1'b0);
        do_req("sb_31", 1'b1, F3_B, 32'h31, 32'h0000_0002, 2, 1'b0);
        do_req("lw_30", 1'b0, F3_W, 32'h30, 32'h0, 1, 1'b0);
        chk("ref_30_low_half", ref_rd(32'h30) & 32'h0000_FFFF, 32'h0000_0201);

        repeat (3) @(negedge clk);
        chk("writes_outstanding", 32'(wq_addr.size()), 32'd0);
        chk("reads_outstanding", 32'(rq_data.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
